// File: rtl/arb_sched_ctrl.sv
// Four-way request arbiter with a programmable grant latency and grant hold.
// Requests queue in pend; one winner at a time is served as WAIT -> GRANT.
module arb_sched_ctrl #(
  parameter int unsigned MIN_DLY  = 3,
  parameter int unsigned HOLD_MAX = 2
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       req1,
  input  logic       req2,
  input  logic       req3,
  input  logic       req4,
  input  logic [2:0] delay_cfg,
  input  logic       hold_cfg,
  input  logic       prio_mode,
  output logic       gnt1,
  output logic       gnt2,
  output logic       gnt3,
  output logic       gnt4,
  output logic [3:0] pend,
  output logic       busy,
  output logic       dup_err
);

  localparam int unsigned CM0  = (HOLD_MAX > 7) ? HOLD_MAX : 7;
  localparam int unsigned CMAX = (MIN_DLY > CM0) ? MIN_DLY : CM0;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] MIN_D  = CW'(MIN_DLY);
  localparam logic [CW-1:0] HOLD_L = CW'(HOLD_MAX);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GRANT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [3:0]    pend_q, pend_d;
  logic          busy_q;
  logic          dup_q, dup_d;
  logic          hold_q, hold_d;
  logic [1:0]    win_q, win_d;
  logic [1:0]    lw_q, lw_d;

  logic [3:0]    req;
  logic [3:0]    cand;
  logic [CW-1:0] cfg_d;
  logic [CW-1:0] d_eff;
  logic [1:0]    sel;
  logic [1:0]    idx;
  logic          hit;

  assign req   = {req4, req3, req2, req1};
  assign cand  = pend_q | req;
  assign cfg_d = CW'(delay_cfg);
  assign d_eff = (cfg_d < MIN_D) ? MIN_D : cfg_d;

  // Round-robin starts the scan just after the last served requester
  always_comb begin
    sel = '0;
    idx = '0;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = prio_mode ? lw_q + 2'(i + 1) : 2'(i);
      if (!hit && cand[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    pend_d  = cand;
    dup_d   = dup_q | (|(req & pend_q));
    hold_d  = hold_q;
    win_d   = win_q;
    lw_d    = lw_q;
    unique case (state_q)
      IDLE: begin
        if (|cand) begin
          pend_d  = cand & ~(4'b0001 << sel);
          win_d   = sel;
          hold_d  = hold_cfg;
          cnt_d   = d_eff;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q <= ONE) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win_q;
          cnt_d   = hold_q ? HOLD_L : ONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      GRANT: begin
        if (cnt_q <= ONE) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          lw_d    = win_q;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      pend_q  <= '0;
      busy_q  <= 1'b0;
      dup_q   <= 1'b0;
      hold_q  <= 1'b0;
      win_q   <= '0;
      lw_q    <= 2'd3;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      pend_q  <= pend_d;
      busy_q  <= (state_d != IDLE);
      dup_q   <= dup_d;
      hold_q  <= hold_d;
      win_q   <= win_d;
      lw_q    <= lw_d;
    end
  end

  assign gnt1    = gnt_q[0];
  assign gnt2    = gnt_q[1];
  assign gnt3    = gnt_q[2];
  assign gnt4    = gnt_q[3];
  assign pend    = pend_q;
  assign busy    = busy_q;
  assign dup_err = dup_q;

endmodule

// File: tb/tb_arb_sched_ctrl.sv
// Bench for arb_sched_ctrl: directed scenarios plus random traffic
// checked against a transaction-timeline reference model.
module tb_arb_sched_ctrl;

  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic [3:0] r     = '0;
  logic [2:0] dc    = '0;
  logic       hc    = 1'b0;
  logic       pm    = 1'b0;

  logic       gnt1, gnt2, gnt3, gnt4;
  logic [3:0] pend;
  logic       busy, dup_err;
  logic [3:0] gv;
  logic [10:0] obs;
  logic [10:0] ev;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  arb_sched_ctrl #(
    .MIN_DLY (3),
    .HOLD_MAX(2)
  ) dut (
    .clock    (clock),
    .rst      (rst),
    .req1     (r[0]),
    .req2     (r[1]),
    .req3     (r[2]),
    .req4     (r[3]),
    .delay_cfg(dc),
    .hold_cfg (hc),
    .prio_mode(pm),
    .gnt1     (gnt1),
    .gnt2     (gnt2),
    .gnt3     (gnt3),
    .gnt4     (gnt4),
    .pend     (pend),
    .busy     (busy),
    .dup_err  (dup_err)
  );

  assign gv  = {gnt4, gnt3, gnt2, gnt1};
  assign obs = {gv, pend, busy, dup_err};

  // Model: one transaction = selection edge plus D and H; outputs
  // follow from where the current edge count falls in that window.
  typedef struct {
    int         n;
    int         sel_e;
    int         d;
    int         h;
    int         win;
    int         last;
    bit         act;
    logic [3:0] pend;
    bit         dup;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t s;
    s.n = 0; s.sel_e = 0; s.d = 0; s.h = 0;
    s.win = 0; s.last = 3; s.act = 0;
    s.pend = '0; s.dup = 0;
    return s;
  endfunction

  function automatic mdl_t mdl_step(mdl_t s, logic [3:0] rq,
                                    logic [2:0] dcf, logic hcf,
                                    logic pmf);
    mdl_t t;
    logic [3:0] c;
    int j, k;
    bit found;
    t = s;
    t.n = s.n + 1;
    t.dup = s.dup || ((rq & s.pend) != 4'b0);
    c = s.pend | rq;
    t.pend = c;
    if ((!s.act || t.n > s.sel_e + s.d + s.h) && c != 4'b0) begin
      found = 0;
      j = 0;
      for (int i = 0; i < 4; i++) begin
        k = pmf ? (s.last + 1 + i) % 4 : i;
        if (!found && c[k]) begin
          found = 1;
          j = k;
        end
      end
      t.pend[j] = 1'b0;
      t.win = j;
      t.last = j;
      t.sel_e = t.n;
      t.d = (int'(dcf) < 3) ? 3 : int'(dcf);
      t.h = hcf ? 2 : 1;
      t.act = 1;
    end
    return t;
  endfunction

  function automatic logic [10:0] mdl_exp(mdl_t s);
    logic [3:0] g;
    logic b;
    int lo;
    g = '0;
    b = 1'b0;
    lo = s.sel_e + s.d + s.h - 1;
    if (s.act && s.n <= lo) b = 1'b1;
    if (s.act && s.n >= s.sel_e + s.d && s.n <= lo)
      g = 4'b0001 << s.win;
    return {g, s.pend, b, s.dup};
  endfunction

  always @(posedge clock or posedge rst) begin
    if (rst) m <= mdl_reset();
    else     m <= mdl_step(m, r, dc, hc, pm);
  end

  task automatic cyc(input logic [3:0] rv);
    @(negedge clock);
    r = rv;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst = 1'b1;
    r = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (gv !== 4'b0) begin
      failures++;
      $display("FAIL reset_gnt: got %b want 0000", gv);
    end
    checks++;
    if (pend !== 4'b0) begin
      failures++;
      $display("FAIL reset_pend: got %b want 0000", pend);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (dup_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_dup: got %b want 0", dup_err);
    end
    @(negedge clock);
    rst = 1'b0;
  endtask

  task automatic test_single();
    int rise, width, bcnt;
    bit pbad;
    rise = -1; width = 0; bcnt = 0; pbad = 0;
    dc = 3'd5; hc = 1'b0; pm = 1'b0;
    cyc(4'b0010);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) cyc(4'b0000);
      ev = mdl_exp(m);
      checks++;
      if (obs !== ev) begin
        failures++;
        $display("FAIL single_model k=%0d: got %b want %b", k, obs, ev);
      end
      if (gv[1]) begin
        if (rise < 0) rise = k;
        width++;
      end
      if (busy) bcnt++;
      if (pend !== 4'b0) pbad = 1;
    end
    checks++;
    if (rise !== 5) begin
      failures++;
      $display("FAIL single_latency: got %0d want 5", rise);
    end
    checks++;
    if (width !== 1) begin
      failures++;
      $display("FAIL single_width: got %0d want 1", width);
    end
    checks++;
    if (bcnt !== 6) begin
      failures++;
      $display("FAIL single_busy: got %0d want 6", bcnt);
    end
    checks++;
    if (pbad !== 1'b0) begin
      failures++;
      $display("FAIL single_pend: got %b want 0", pbad);
    end
  endtask

  task automatic test_clamp_hold();
    int rise, width;
    rise = -1; width = 0;
    dc = 3'd1; hc = 1'b1; pm = 1'b0;
    cyc(4'b0001);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) cyc(4'b0000);
      ev = mdl_exp(m);
      checks++;
      if (obs !== ev) begin
        failures++;
        $display("FAIL clamp_model k=%0d: got %b want %b", k, obs, ev);
      end
      if (gv[0]) begin
        if (rise < 0) rise = k;
        width++;
      end
    end
    checks++;
    if (rise !== 3) begin
      failures++;
      $display("FAIL clamp_latency: got %0d want 3", rise);
    end
    checks++;
    if (width !== 2) begin
      failures++;
      $display("FAIL clamp_width: got %0d want 2", width);
    end
  endtask

  task automatic test_fixed_prio();
    int code;
    logic [3:0] pg;
    code = 0; pg = '0;
    do_reset();
    dc = 3'd3; hc = 1'b1; pm = 1'b0;
    cyc(4'b1111);
    checks++;
    if (pend !== 4'b1110) begin
      failures++;
      $display("FAIL fixed_pend0: got %b want 1110", pend);
    end
    for (int k = 0; k < 30; k++) begin
      if (k > 0) cyc(4'b0000);
      ev = mdl_exp(m);
      checks++;
      if (obs !== ev || $countones(gv) > 1) begin
        failures++;
        $display("FAIL fixed_model k=%0d: got %b want %b", k, obs, ev);
      end
      if (gv != 4'b0 && gv != pg) code = code * 10 + $clog2(gv) + 1;
      pg = gv;
    end
    checks++;
    if (code !== 1234) begin
      failures++;
      $display("FAIL fixed_order: got %0d want 1234", code);
    end
    checks++;
    if (pend !== 4'b0) begin
      failures++;
      $display("FAIL fixed_pend_end: got %b want 0000", pend);
    end
  endtask

  task automatic test_round_robin();
    int code;
    logic [3:0] pg;
    code = 0; pg = '0;
    do_reset();
    dc = 3'd3; hc = 1'b0; pm = 1'b1;
    cyc(4'b0100);
    cyc(4'b1001);
    checks++;
    if (pend !== 4'b1001) begin
      failures++;
      $display("FAIL rr_pend: got %b want 1001", pend);
    end
    for (int k = 0; k < 25; k++) begin
      if (k > 0) cyc(4'b0000);
      ev = mdl_exp(m);
      checks++;
      if (obs !== ev) begin
        failures++;
        $display("FAIL rr_model k=%0d: got %b want %b", k, obs, ev);
      end
      if (gv != 4'b0 && gv != pg) code = code * 10 + $clog2(gv) + 1;
      pg = gv;
    end
    checks++;
    if (code !== 341) begin
      failures++;
      $display("FAIL rr_order: got %0d want 341", code);
    end
  endtask

  task automatic test_dup_reset();
    logic [3:0] gseen;
    gseen = '0;
    do_reset();
    dc = 3'd4; hc = 1'b0; pm = 1'b0;
    cyc(4'b0101);
    checks++;
    if (pend !== 4'b0100) begin
      failures++;
      $display("FAIL dup_queue: got %b want 0100", pend);
    end
    cyc(4'b0100);
    checks++;
    if (dup_err !== 1'b1) begin
      failures++;
      $display("FAIL dup_flag: got %b want 1", dup_err);
    end
    checks++;
    if (pend !== 4'b0100) begin
      failures++;
      $display("FAIL dup_drop: got %b want 0100", pend);
    end
    cyc(4'b0000);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL dup_busy: got %b want 1", busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 11'b0) begin
      failures++;
      $display("FAIL async_reset: got %b want 0", obs);
    end
    @(negedge clock);
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      cyc(4'b0000);
      gseen = gseen | gv;
      ev = mdl_exp(m);
      checks++;
      if (obs !== ev) begin
        failures++;
        $display("FAIL post_reset k=%0d: got %b want %b", k, obs, ev);
      end
    end
    checks++;
    if (gseen !== 4'b0) begin
      failures++;
      $display("FAIL post_reset_gnt: got %b want 0000", gseen);
    end
  endtask

  task automatic test_random();
    logic [3:0] rv;
    do_reset();
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      dc = 3'($urandom_range(0, 7));
      hc = 1'($urandom_range(0, 1));
      pm = 1'($urandom_range(0, 1));
      for (int b = 0; b < 4; b++) rv[b] = ($urandom_range(0, 6) == 0);
      cyc(rv);
      ev = mdl_exp(m);
      checks++;
      if (obs !== ev || $countones(gv) > 1) begin
        failures++;
        $display("FAIL random k=%0d: got %b want %b", k, obs, ev);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_clamp_hold();
    test_fixed_prio();
    test_round_robin();
    test_dup_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arb_sched_ctrl.md
ARB_SCHED_CTRL -- requirements
Module: arb_sched_ctrl

Interface
REQ-001 Parameter MIN_DLY, default 3, minimum grant latency in cycles; delay_cfg values below it are clamped to it.
REQ-002 Parameter HOLD_MAX, default 2, maximum grant duration in cycles.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req1, req2, req3, req4  input  1 each  request pulses; req1 is the lowest index.
REQ-006 delay_cfg  input  3  grant latency D; effective value is max(delay_cfg, MIN_DLY).
REQ-007 hold_cfg  input  1  grant duration: 0 = 1 cycle, 1 = HOLD_MAX cycles.
REQ-008 prio_mode  input  1  0 = fixed priority (req1 highest), 1 = round-robin.
REQ-009 gnt1, gnt2, gnt3, gnt4  output  1 each  registered grants; at most one is high at a time.
REQ-010 pend  output  4  queued requests; bit0 is req1.
REQ-011 busy  output  1  high whenever the FSM is not IDLE.
REQ-012 dup_err  output  1  sticky flag: a request arrived while that requester was already pending.

Function
REQ-013 The block SHALL implement a 3-state FSM: IDLE, WAIT, GRANT.
REQ-014 On each edge with reqN=1, pend[N-1] SHALL be set unless the IDLE selection on the same edge consumes that request.
REQ-015 On an edge with reqN=1 while pend[N-1] is already 1, dup_err SHALL set; the request is dropped.
REQ-016 IDLE: candidates = pend | {req4,req3,req2,req1}; if any candidate is set, one winner SHALL be selected on that edge. Selection actions:
  - clear the winner's pend bit;
  - latch effective D and hold_cfg;
  - load cnt=D;
  - go to WAIT.
REQ-017 Fixed mode: the winner SHALL be the lowest index. Round-robin mode: search SHALL start at last_winner+1 mod 4.
REQ-018 Later changes to delay_cfg, hold_cfg and prio_mode SHALL NOT affect an in-flight grant.
REQ-019 WAIT: cnt SHALL decrement each edge. On the edge where cnt==1, the FSM SHALL go to GRANT and the winner's gnt register SHALL be set. Result: a request sampled at edge N with the FSM idle is granted (gnt sampled high) at edge N+1+D.
REQ-020 GRANT: gnt SHALL stay high for exactly 1 or HOLD_MAX cycles per latched hold_cfg. It then SHALL deassert and the FSM SHALL return to IDLE. last_winner SHALL update on that edge.
REQ-021 The next selection SHALL occur no earlier than the first IDLE edge after gnt falls, so grants are never back-to-back without at least one low cycle.
REQ-022 A request from the currently served requester during WAIT or GRANT SHALL be queued in pend (not a duplicate).
REQ-023 Simultaneous requests on one edge SHALL all be queued or served; none SHALL be lost.
REQ-024 gnt1..gnt4 SHALL be one-hot or all-zero in every cycle.
REQ-025 busy SHALL equal (state != IDLE), registered.

Reset
REQ-026 While rst=1, the block SHALL asynchronously force the following, independent of clock:
  - state=IDLE;
  - gnt1..gnt4=0, pend=0, busy=0, dup_err=0, cnt=0;
  - last_winner=3 (so req1 has first round-robin priority).
REQ-027 Reset asserted mid-WAIT or mid-GRANT SHALL abort the transaction with no grant emitted after rst falls. The first edge after release SHALL behave as IDLE.

Verification
REQ-028 Single request: delay_cfg=5, hold_cfg=0, req2 pulsed at edge 10 -> gnt2 high at edge 16 only; busy high during edges 11-16; pend stays 0.
REQ-029 Clamp and hold: delay_cfg=1, hold_cfg=1, req1 at edge 4 -> gnt1 high at edges 8-9, low at 10.
REQ-030 Fixed priority contention: prio_mode=0, req1..req4 all pulsed at edge 0, D=3, hold 1 -> grants in order gnt1, gnt2, gnt3, gnt4. pend reads 4'b1110 after edge 0 and is 0 after the last selection. Never two gnts at once.
REQ-031 Round-robin: prio_mode=1, after a gnt3 completes, req1 and req4 pending -> gnt4 served before gnt1.
REQ-032 Duplicate plus reset: req3 at edge 2, req1 at edge 2 (so req3 is queued), req3 again at edge 3 -> dup_err=1. rst pulsed mid-WAIT -> all outputs 0 immediately and no grant afterwards.
